// File: rtl/game_judge_m.sv
// Tic-tac-toe board judge: snapshots the board on start, scans the 8 win lines one per clock, reports the outcome.
// Optional JUDGE_WIN_LINE_EN adds a win_line output with the index of the first winning line.
module game_judge_m #(
    parameter int unsigned       CELL_W = 2,
    parameter logic [CELL_W-1:0] CELL_X = CELL_W'(2'b01),
    parameter logic [CELL_W-1:0] CELL_O = CELL_W'(2'b10)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [9*CELL_W-1:0]   board,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            result,
    output logic                  game_over
`ifdef JUDGE_WIN_LINE_EN
   ,output logic [2:0]            win_line
`endif
);

    localparam int unsigned N_CELLS = 9;
    localparam int unsigned N_LINES = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned CIDX_W  = 4;
    localparam int unsigned RES_W   = 3;
    localparam int unsigned BOARD_W = N_CELLS * CELL_W;

    localparam logic [CELL_W-1:0] CELL_BLANK = '0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_RESULT = 2'd2;

    localparam logic [RES_W-1:0] RES_ONGOING = 3'b000;
    localparam logic [RES_W-1:0] RES_X_WIN   = 3'b001;
    localparam logic [RES_W-1:0] RES_O_WIN   = 3'b010;
    localparam logic [RES_W-1:0] RES_DRAW    = 3'b011;
    localparam logic [RES_W-1:0] RES_ILLEGAL = 3'b100;

    localparam logic [IDX_W-1:0] LAST_LINE = IDX_W'(N_LINES - 1);

    // Cell indices {c2, c1, c0} of each win line, 4 bits per index.
    function automatic logic [3*CIDX_W-1:0] line_cells(input logic [IDX_W-1:0] idx);
        logic [3*CIDX_W-1:0] cells;
        case (idx)
            3'd0:    cells = {4'd2, 4'd1, 4'd0};
            3'd1:    cells = {4'd5, 4'd4, 4'd3};
            3'd2:    cells = {4'd8, 4'd7, 4'd6};
            3'd3:    cells = {4'd6, 4'd3, 4'd0};
            3'd4:    cells = {4'd7, 4'd4, 4'd1};
            3'd5:    cells = {4'd8, 4'd5, 4'd2};
            3'd6:    cells = {4'd8, 4'd4, 4'd0};
            default: cells = {4'd6, 4'd4, 4'd2};
        endcase
        return cells;
    endfunction

    // Mux one cell code out of the flattened board using constant part-selects.
    function automatic logic [CELL_W-1:0] get_cell(input logic [BOARD_W-1:0] b,
                                                   input logic [CIDX_W-1:0]  c);
        logic [CELL_W-1:0] v;
        v = CELL_BLANK;
        for (int i = 0; i < int'(N_CELLS); i++) begin
            if (c == CIDX_W'(i)) v = b[CELL_W*i +: CELL_W];
        end
        return v;
    endfunction

    logic [1:0]         state_q,    state_d;
    logic [BOARD_W-1:0] snapshot_q, snapshot_d;
    logic [IDX_W-1:0]   line_idx_q, line_idx_d;
    logic               xw_q, xw_d;
    logic               ow_q, ow_d;
    logic               bad_q, bad_d;
    logic               busy_d;
    logic               done_d;
    logic [RES_W-1:0]   result_d;
    logic               game_over_d;
`ifdef JUDGE_WIN_LINE_EN
    logic [IDX_W-1:0]   first_q, first_d;
    logic [IDX_W-1:0]   win_line_d;
`endif

    logic [3*CIDX_W-1:0] cur_cells_c;
    logic [CELL_W-1:0]   cell_a_c, cell_b_c, cell_c_c;
    logic                line_x_c, line_o_c;
    logic                has_blank_c, has_bad_code_c;

    // Current line evaluation from the snapshot.
    always_comb begin
        cur_cells_c = line_cells(line_idx_q);
        cell_a_c    = get_cell(snapshot_q, cur_cells_c[CIDX_W-1:0]);
        cell_b_c    = get_cell(snapshot_q, cur_cells_c[2*CIDX_W-1:CIDX_W]);
        cell_c_c    = get_cell(snapshot_q, cur_cells_c[3*CIDX_W-1:2*CIDX_W]);
        line_x_c    = (cell_a_c == CELL_X) && (cell_b_c == CELL_X) && (cell_c_c == CELL_X);
        line_o_c    = (cell_a_c == CELL_O) && (cell_b_c == CELL_O) && (cell_c_c == CELL_O);
    end

    // Whole-board checks: any blank cell, any code outside {blank, X, O}.
    always_comb begin
        has_blank_c    = 1'b0;
        has_bad_code_c = 1'b0;
        for (int i = 0; i < int'(N_CELLS); i++) begin
            if (snapshot_q[CELL_W*i +: CELL_W] == CELL_BLANK) begin
                has_blank_c = 1'b1;
            end else if ((snapshot_q[CELL_W*i +: CELL_W] != CELL_X) &&
                         (snapshot_q[CELL_W*i +: CELL_W] != CELL_O)) begin
                has_bad_code_c = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        snapshot_d  = snapshot_q;
        line_idx_d  = line_idx_q;
        xw_d        = xw_q;
        ow_d        = ow_q;
        bad_d       = bad_q;
        done_d      = 1'b0;
        result_d    = result;
        game_over_d = game_over;
`ifdef JUDGE_WIN_LINE_EN
        first_d     = first_q;
        win_line_d  = win_line;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SCAN;
                    snapshot_d = board;
                    line_idx_d = '0;
                    xw_d       = 1'b0;
                    ow_d       = 1'b0;
                    bad_d      = 1'b0;
`ifdef JUDGE_WIN_LINE_EN
                    first_d    = '0;
`endif
                end
            end

            ST_SCAN: begin
                if (line_x_c) xw_d = 1'b1;
                if (line_o_c) ow_d = 1'b1;
`ifdef JUDGE_WIN_LINE_EN
                if ((line_x_c || line_o_c) && !(xw_q || ow_q)) first_d = line_idx_q;
`endif
                if (line_idx_q == LAST_LINE) begin
                    state_d = ST_RESULT;
                end else begin
                    line_idx_d = line_idx_q + IDX_W'(1);
                end
            end

            ST_RESULT: begin
                bad_d = has_bad_code_c || (xw_q && ow_q);
                if (bad_d)           result_d = RES_ILLEGAL;
                else if (xw_q)       result_d = RES_X_WIN;
                else if (ow_q)       result_d = RES_O_WIN;
                else if (!has_blank_c) result_d = RES_DRAW;
                else                 result_d = RES_ONGOING;
                game_over_d = (result_d != RES_ONGOING);
                done_d      = 1'b1;
                state_d     = ST_IDLE;
`ifdef JUDGE_WIN_LINE_EN
                win_line_d  = ((result_d == RES_X_WIN) || (result_d == RES_O_WIN)) ? first_q : '0;
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            snapshot_q <= '0;
            line_idx_q <= '0;
            xw_q       <= 1'b0;
            ow_q       <= 1'b0;
            bad_q      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= RES_ONGOING;
            game_over  <= 1'b0;
`ifdef JUDGE_WIN_LINE_EN
            first_q    <= '0;
            win_line   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            snapshot_q <= snapshot_d;
            line_idx_q <= line_idx_d;
            xw_q       <= xw_d;
            ow_q       <= ow_d;
            bad_q      <= bad_d;
            busy       <= busy_d;
            done       <= done_d;
            result     <= result_d;
            game_over  <= game_over_d;
`ifdef JUDGE_WIN_LINE_EN
            first_q    <= first_d;
            win_line   <= win_line_d;
`endif
        end
    end

endmodule

// File: tb/tb_game_judge_m.sv
// Directed self-checking bench for game_judge_m: outcomes, latency, busy-drop, back-to-back and mid-scan reset.
module tb_game_judge_m;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] X = 2'b01;
    localparam logic [1:0] O = 2'b10;
    localparam logic [1:0] I = 2'b11;

    logic        clk;
    logic        reset_n;
    logic [17:0] board;
    logic        start;
    logic        busy;
    logic        done;
    logic [2:0]  result;
    logic        game_over;
`ifdef JUDGE_WIN_LINE_EN
    logic [2:0]  win_line;
`endif

    int tests_run;
    int tests_failed;

    game_judge_m dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .board     (board),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .game_over (game_over)
`ifdef JUDGE_WIN_LINE_EN
       ,.win_line  (win_line)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] mk(input logic [1:0] c0, c1, c2, c3, c4, c5, c6, c7, c8);
        return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
    endfunction

    // One judgement: pulse start with board b, wait for done, check latency and outputs.
    task automatic run_judge(input string tag, input logic [17:0] b,
                             input logic [2:0] exp_res, input logic [2:0] exp_line);
        int   n;
        logic seen;
        @(negedge clk);
        board = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            n++;
            #1 seen = done;
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
        check({tag, "_lat"}, 32'(n), 32'd9);
        check({tag, "_res"}, 32'(result), 32'(exp_res));
        check({tag, "_over"}, 32'(game_over), 32'(exp_res != 3'b000));
        check({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef JUDGE_WIN_LINE_EN
        check({tag, "_line"}, 32'(win_line), 32'(exp_line));
`else
        if (exp_line != 3'd0) n = 0;
`endif
        @(posedge clk);
        #1 check({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int   n;
        int   dones;
        logic seen;
        logic [2:0] res_at_done;

        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        start        = 1'b0;
        board        = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", 32'(result), 32'd0);
        check("rst_over", 32'(game_over), 32'd0);
        @(negedge clk) reset_n = 1'b1;

        run_judge("empty",   mk(B,B,B,B,B,B,B,B,B), 3'b000, 3'd0);
        run_judge("xrow",    mk(X,X,X,O,O,B,B,B,B), 3'b001, 3'd0);
        run_judge("odiag",   mk(X,X,O,B,O,X,O,B,X), 3'b010, 3'd7);
        run_judge("xcol",    mk(B,O,X,B,O,X,B,B,X), 3'b001, 3'd5);
        run_judge("fullwin", mk(X,X,X,O,O,X,O,X,O), 3'b001, 3'd0);
        run_judge("badcell", mk(B,B,B,B,B,I,B,B,B), 3'b100, 3'd0);
        run_judge("bothwin", mk(X,X,X,O,O,O,B,B,B), 3'b100, 3'd0);
        run_judge("draw",    mk(X,O,X,X,O,O,O,X,X), 3'b011, 3'd0);

        // Board change and second start while busy: dropped, snapshot kept.
        @(negedge clk);
        board = mk(X,X,X,O,O,B,B,B,B);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        board = mk(B,B,B,B,B,B,B,B,B);
        start = 1'b1;
        check("drop_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1 start = 1'b0;
        dones       = 0;
        res_at_done = 3'b111;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                res_at_done = result;
            end
        end
        check("drop_dones", 32'(dones), 32'd1);
        check("drop_res", 32'(res_at_done), 32'b001);
        check("drop_hold", 32'(result), 32'b001);

        // Start held high: back-to-back scans every 10 clocks.
        @(negedge clk);
        board = mk(X,X,O,B,O,X,O,B,X);
        start = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 25) begin
            @(posedge clk);
            n++;
            #1 seen = done;
        end
        check("b2b_first", 32'(seen), 32'd1);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 25) begin
            @(posedge clk);
            n++;
            #1 seen = done;
        end
        start = 1'b0;
        check("b2b_second", 32'(seen), 32'd1);
        check("b2b_period", 32'(n), 32'd10);
        check("b2b_res", 32'(result), 32'b010);
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1 if (done) dones++;
        end
        check("b2b_stop", 32'(dones), 32'd0);

        // Reset in the middle of a scan.
        @(negedge clk);
        board = mk(X,X,X,O,O,B,B,B,B);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("mid_busy", 32'(busy), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_res", 32'(result), 32'd0);
        check("mid_rst_over", 32'(game_over), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1 if (done) dones++;
        end
        check("mid_no_done", 32'(dones), 32'd0);
        check("mid_idle", 32'(busy), 32'd0);

        run_judge("postrst", mk(X,X,X,O,O,B,B,B,B), 3'b001, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
